// File: rtl/arb_mem_server_pkg.sv
// Shared constants, completion-type encoding and helper function for the
// arbitrated memory server.
package arb_mem_server_pkg;

    // Position of the write flag inside server_serv_data.
    localparam int WR_BIT_POS = 0;

    // Completion type recorded per acked request in the tag FIFO.
    typedef enum logic {
        CMPL_READ  = 1'b0,
        CMPL_WRITE = 1'b1
    } cmpl_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int log2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/arb_mem_server_if.sv
// Server-side request/completion bus from the arbitrator and the pipelined
// memory port bus driven by the server.
interface arb_mem_server_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 36
);
    logic [ADDR_WIDTH-1:0] server_supp_data;
    logic [DATA_WIDTH:0]   server_serv_data;
    logic                  server_req;
    logic                  server_ack;
    logic                  server_vld;
    logic [DATA_WIDTH-1:0] server_rslt_data;

    modport master (
        output server_supp_data, server_serv_data, server_req,
        input  server_ack, server_vld, server_rslt_data
    );

    modport slave (
        input  server_supp_data, server_serv_data, server_req,
        output server_ack, server_vld, server_rslt_data
    );
endinterface

interface arb_mem_port_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 36
);
    logic                  mem_req;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_rdata_vld;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata, mem_rdata_vld
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_ready, mem_rdata, mem_rdata_vld
    );
endinterface

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: dout shows the head entry whenever the
// FIFO is not empty. Writes when full and reads when empty are ignored.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    input  logic             reset,
    input  logic             clk
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] FULL_CNT = (MAX_DEPTH_BITS + 1)'(DEPTH);

    logic [WIDTH-1:0]          queue [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      do_wr;
    logic                      do_rd;

    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    assign full  = (depth == FULL_CNT);
    assign empty = (depth == '0);
    assign dout  = queue[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            queue[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            depth  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   depth <= depth + 1'b1;
                2'b01:   depth <= depth - 1'b1;
                default: depth <= depth;
            endcase
        end
    end

endmodule

// File: rtl/arb_mem_server.sv
// Forwards arbitrated requests to a pipelined memory port under a credit
// limit and returns one in-order completion per acked request.
module arb_mem_server
    import arb_mem_server_pkg::*;
#(
    parameter int ADDR_WIDTH     = 19,
    parameter int DATA_WIDTH     = 36,
    parameter int MAX_OUTST_BITS = 2
) (
    input  logic            clk,
    input  logic            reset,
    arb_mem_server_if.slave srv,
    arb_mem_port_if.master  mem,
    output logic            protocol_err
);
    localparam int OUTST_MAX = 1 << MAX_OUTST_BITS;
    localparam int CNT_W     = log2(OUTST_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUTST_MAX);

    logic [CNT_W-1:0]      outst_cnt;
    logic [CNT_W-1:0]      rd_outst;
    logic                  credit_ok;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;

    logic [0:0]            tag_din;
    logic [0:0]            tag_head;
    logic                  tag_full;
    logic                  tag_empty;
    logic                  tag_head_wr;

    logic [DATA_WIDTH-1:0] rdata_head;
    logic                  rdata_full;
    logic                  rdata_empty;
    logic                  rdata_push;
    logic                  rdata_pop;
    logic                  rd_data_ok;
    logic                  pop;

    // Request path: purely combinational so an ack lands in the same cycle.
    assign credit_ok      = (outst_cnt < CNT_MAX);
    assign req_wr         = srv.server_serv_data[WR_BIT_POS];
    assign req_addr       = srv.server_supp_data;
    assign mem.mem_req    = srv.server_req & credit_ok;
    assign mem.mem_wr     = req_wr;
    assign mem.mem_addr   = req_addr;
    assign mem.mem_wdata  = srv.server_serv_data[DATA_WIDTH:1];
    assign srv.server_ack = mem.mem_req & mem.mem_ready;

    assign tag_din     = req_wr ? CMPL_WRITE : CMPL_READ;
    assign tag_head_wr = (tag_head == CMPL_WRITE);

    // Read data with no read outstanding is dropped rather than queued.
    assign rd_data_ok = mem.mem_rdata_vld & (rd_outst != '0);
    assign rdata_push = rd_data_ok & ~rdata_full;

    assign pop       = ~tag_empty & (tag_head_wr | ~rdata_empty);
    assign rdata_pop = pop & ~tag_head_wr;

    fallthrough_small_fifo #(
        .WIDTH          (1),
        .MAX_DEPTH_BITS (MAX_OUTST_BITS)
    ) tag_fifo (
        .din   (tag_din),
        .wr_en (srv.server_ack & ~tag_full),
        .rd_en (pop),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .reset (reset),
        .clk   (clk)
    );

    fallthrough_small_fifo #(
        .WIDTH          (DATA_WIDTH),
        .MAX_DEPTH_BITS (MAX_OUTST_BITS)
    ) rdata_fifo (
        .din   (mem.mem_rdata),
        .wr_en (rdata_push),
        .rd_en (rdata_pop),
        .dout  (rdata_head),
        .full  (rdata_full),
        .empty (rdata_empty),
        .reset (reset),
        .clk   (clk)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            outst_cnt            <= '0;
            rd_outst             <= '0;
            srv.server_vld       <= 1'b0;
            srv.server_rslt_data <= '0;
            protocol_err         <= 1'b0;
        end else begin
            case ({srv.server_ack, pop})
                2'b10:   outst_cnt <= outst_cnt + 1'b1;
                2'b01:   outst_cnt <= outst_cnt - 1'b1;
                default: outst_cnt <= outst_cnt;
            endcase

            case ({srv.server_ack & ~req_wr, rd_data_ok})
                2'b10:   rd_outst <= rd_outst + 1'b1;
                2'b01:   rd_outst <= rd_outst - 1'b1;
                default: rd_outst <= rd_outst;
            endcase

            srv.server_vld <= pop;
            if (pop) begin
                srv.server_rslt_data <= tag_head_wr ? '0 : rdata_head;
            end

            if (mem.mem_rdata_vld & (rdata_full | (rd_outst == '0))) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule
